// File: rtl/router_pkg.sv
// router_pkg: shared FSM states and sizing constants for the three-port packet router
package router_pkg;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int CW = AW + 1;
  localparam int TW = 5;
  localparam int TIMEOUT = 30;
  typedef enum logic [2:0] {
    DECODE,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY
  } state_t;
endpackage

// File: rtl/router_fifo.sv
// router_fifo: 16x8 output FIFO with registered read data and a 30-cycle unread-data flush timer
module router_fifo
  import router_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          soft_rst
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic do_w, do_r, stall;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_w = we & ~full;
    do_r = re & ~empty;
    stall = ~empty & ~re;
    soft_rst = stall & (tmr_q == TW'(TIMEOUT - 1));
    tmr_d = stall & ~soft_rst ? tmr_q + TW'(1) : '0;
    wptr_d = soft_rst ? '0 : wptr_q + AW'(do_w);
    rptr_d = soft_rst ? '0 : rptr_q + AW'(do_r);
    cnt_d = soft_rst ? '0 : cnt_q + CW'(do_w) - CW'(do_r);
    dout_d = do_r ? mem_q[rptr_q] : dout_q;
    dout = dout_q;
  end
  always_ff @(posedge clock) begin
    if (do_w) mem_q[wptr_q] <= din;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: rtl/router_top.sv
// router_top: steers byte-serial packets into three FIFOs by header address, checks XOR parity, drives busy backpressure
module router_top
  import router_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          read_enb_0,
  input  logic          read_enb_1,
  input  logic          read_enb_2,
  input  logic [DW-1:0] data_in,
  input  logic          pkt_valid,
  output logic [DW-1:0] data_out_0,
  output logic [DW-1:0] data_out_1,
  output logic [DW-1:0] data_out_2,
  output logic          vld_out_0,
  output logic          vld_out_1,
  output logic          vld_out_2,
  output logic          error,
  output logic          busy
);
  state_t state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [DW-1:0] parity_q, parity_d, rx_par_q, rx_par_d, wdata;
  logic [DW:0] hold_q, hold_d;
  logic err_q, err_d, wr;
  logic [2:0] re_v, we_v, emp_v, ful_v, srt_v;
  logic [3:0] emp4, ful4, srt4;
  logic [DW-1:0] dout_v [3];
  assign re_v = {read_enb_2, read_enb_1, read_enb_0};
  assign emp4 = {1'b1, emp_v};
  assign ful4 = {1'b0, ful_v};
  assign srt4 = {1'b0, srt_v};
  for (genvar i = 0; i < 3; i++) begin : g_fifo
    router_fifo u_fifo (
      .clock    (clock),
      .resetn   (resetn),
      .we       (we_v[i]),
      .din      (wdata),
      .re       (re_v[i]),
      .dout     (dout_v[i]),
      .empty    (emp_v[i]),
      .full     (ful_v[i]),
      .soft_rst (srt_v[i])
    );
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    parity_d = parity_q;
    rx_par_d = rx_par_q;
    hold_d = hold_q;
    err_d = err_q;
    wr = 1'b0;
    wdata = data_in;
    case (state_q)
      DECODE: begin
        if (pkt_valid && data_in[1:0] != 2'd3) begin
          addr_d = data_in[1:0];
          err_d = 1'b0;
          state_d = emp4[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: state_d = emp4[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA: begin
        wr = 1'b1;
        parity_d = data_in;
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (!pkt_valid) begin
          rx_par_d = data_in;
          state_d = LOAD_PARITY;
        end else if (ful4[addr_q]) begin
          hold_d = {1'b0, data_in};
          state_d = FIFO_FULL;
        end else begin
          wr = 1'b1;
          parity_d = parity_q ^ data_in;
        end
      end
      FIFO_FULL: state_d = ful4[addr_q] ? FIFO_FULL : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        wr = 1'b1;
        wdata = hold_q[DW-1:0];
        parity_d = hold_q[DW] ? parity_q : parity_q ^ hold_q[DW-1:0];
        state_d = hold_q[DW] ? CHECK_PARITY : LOAD_DATA;
      end
      LOAD_PARITY: begin
        wdata = rx_par_q;
        if (ful4[addr_q]) begin
          hold_d = {1'b1, rx_par_q};
          state_d = FIFO_FULL;
        end else begin
          wr = 1'b1;
          state_d = CHECK_PARITY;
        end
      end
      CHECK_PARITY: begin
        err_d = parity_q != rx_par_q;
        state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase
    if (state_q != DECODE && srt4[addr_q]) begin
      state_d = DECODE;
      wr = 1'b0;
    end
    we_v = wr ? 3'b001 << addr_q : 3'b000;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE;
      addr_q <= '0;
      parity_q <= '0;
      rx_par_q <= '0;
      hold_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      parity_q <= parity_d;
      rx_par_q <= rx_par_d;
      hold_q <= hold_d;
      err_q <= err_d;
    end
  end
  assign data_out_0 = dout_v[0];
  assign data_out_1 = dout_v[1];
  assign data_out_2 = dout_v[2];
  assign vld_out_0 = ~emp_v[0];
  assign vld_out_1 = ~emp_v[1];
  assign vld_out_2 = ~emp_v[2];
  assign error = err_q;
  assign busy = state_q != DECODE && state_q != LOAD_DATA;
endmodule

// File: tb/tb_router_top.sv
// tb_router_top: directed packets with a per-port expected-byte scoreboard checked by an independent pop monitor
module tb_router_top;
  logic clock, resetn, read_enb_0, read_enb_1, read_enb_2, pkt_valid;
  logic [7:0] data_in, data_out_0, data_out_1, data_out_2;
  logic vld_out_0, vld_out_1, vld_out_2, error, busy;
  logic [7:0] q0[$], q1[$], q2[$];
  int checks = 0;
  int fails = 0;
  router_top dut (
    .clock      (clock),
    .resetn     (resetn),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .data_in    (data_in),
    .pkt_valid  (pkt_valid),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .error      (error),
    .busy       (busy)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic pop_chk(input int p, input logic [7:0] got);
    logic [7:0] e;
    int n;
    n = p == 0 ? q0.size() : p == 1 ? q1.size() : q2.size();
    checks++;
    if (n == 0) begin
      fails++;
      $display("FAIL pop_port%0d unexpected byte got=%h exp=none", p, got);
    end else begin
      if (p == 0) e = q0.pop_front();
      else if (p == 1) e = q1.pop_front();
      else e = q2.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL pop_port%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask
  initial begin
    logic [2:0] pop;
    forever begin
      @(posedge clock);
      pop = {read_enb_2 & vld_out_2, read_enb_1 & vld_out_1, read_enb_0 & vld_out_0};
      #1;
      if (pop[0]) pop_chk(0, data_out_0);
      if (pop[1]) pop_chk(1, data_out_1);
      if (pop[2]) pop_chk(2, data_out_2);
    end
  end
  task automatic send(input logic [7:0] b[$], input bit push, input int bound, output int stuck);
    logic [1:0] a;
    a = b[0][1:0];
    stuck = -1;
    if (push)
      for (int i = 0; i < b.size(); i++) begin
        if (a == 2'd0) q0.push_back(b[i]);
        else if (a == 2'd1) q1.push_back(b[i]);
        else if (a == 2'd2) q2.push_back(b[i]);
      end
    for (int i = 0; i < b.size(); i++) begin
      data_in = b[i];
      pkt_valid = i != b.size() - 1;
      @(negedge clock);
      for (int g = 0; busy && g < bound; g++) @(negedge clock);
      if (busy) begin
        stuck = i;
        return;
      end
    end
  endtask
  task automatic mk18(input logic [7:0] base, output logic [7:0] b[$]);
    logic [7:0] p;
    b = {};
    b.push_back(8'h49);
    p = 8'h49;
    for (int i = 0; i < 18; i++) begin
      b.push_back(base + 8'(i));
      p = p ^ (base + 8'(i));
    end
    b.push_back(p);
  endtask
  initial begin
    logic [7:0] b[$];
    int st;
    int g;
    resetn = 1'b0;
    pkt_valid = 1'b0;
    data_in = 8'h00;
    read_enb_0 = 1'b0;
    read_enb_1 = 1'b0;
    read_enb_2 = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_flags", {29'd0, vld_out_2, vld_out_1, vld_out_0} | {30'd0, error, busy}, 32'd0);
    chk("rst_dout", {8'd0, data_out_2, data_out_1, data_out_0}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    b = {8'h16, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h17};
    send(b, 1'b1, 200, st);
    chk("t1_stuck", st, -1);
    chk("t1_error", error, 0);
    chk("t1_vld", {vld_out_2, vld_out_1, vld_out_0}, 3'b100);
    repeat (10) @(negedge clock);
    read_enb_2 = 1'b1;
    repeat (9) @(negedge clock);
    read_enb_2 = 1'b0;
    chk("t1_drained", q2.size(), 0);
    chk("t1_vld2_low", vld_out_2, 0);
    repeat (3) @(negedge clock);
    chk("t1_dout_hold", data_out_2, 8'h17);
    b = {8'h0C, 8'hA0, 8'hA1, 8'hA2, 8'hAE};
    send(b, 1'b1, 200, st);
    chk("t2_stuck", st, -1);
    chk("t2_error", error, 1);
    read_enb_0 = 1'b1;
    repeat (7) @(negedge clock);
    read_enb_0 = 1'b0;
    chk("t2_drained", q0.size(), 0);
    mk18(8'h30, b);
    send(b, 1'b0, 8, st);
    chk("t3_writes_before_full", st, 16);
    chk("t3_busy_full", busy, 1);
    chk("t3_vld1", vld_out_1, 1);
    chk("t3_error_cleared", error, 0);
    g = 0;
    while (busy && g < 40) begin
      @(negedge clock);
      g++;
    end
    pkt_valid = 1'b0;
    chk("t3_flush_abort", busy, 0);
    chk("t3_flushed", vld_out_1, 0);
    repeat (2) @(negedge clock);
    chk("t3_idle", {busy, vld_out_1}, 2'b00);
    mk18(8'h50, b);
    read_enb_1 = 1'b1;
    send(b, 1'b1, 200, st);
    chk("t4_stuck", st, -1);
    chk("t4_error", error, 0);
    repeat (4) @(negedge clock);
    read_enb_1 = 1'b0;
    chk("t4_drained", q1.size(), 0);
    b = {8'h08, 8'h11, 8'h22, 8'h3B};
    send(b, 1'b1, 200, st);
    chk("t5a_stuck", st, -1);
    b = {8'h04, 8'h5A, 8'h5E};
    fork
      send(b, 1'b1, 200, st);
      begin
        repeat (6) @(negedge clock);
        chk("t5_wait_busy", busy, 1);
        chk("t5_vld0", vld_out_0, 1);
        read_enb_0 = 1'b1;
      end
    join
    chk("t5b_stuck", st, -1);
    chk("t5_error", error, 0);
    repeat (3) @(negedge clock);
    read_enb_0 = 1'b0;
    chk("t5_drained", q0.size(), 0);
    data_in = 8'h07;
    pkt_valid = 1'b1;
    @(negedge clock);
    pkt_valid = 1'b0;
    chk("t6_addr3_busy", busy, 0);
    repeat (3) @(negedge clock);
    chk("t6_addr3_quiet", {vld_out_2, vld_out_1, vld_out_0, busy}, 4'b0000);
    b = {8'h06, 8'h01, 8'h06};
    send(b, 1'b0, 200, st);
    chk("t6_bad_error", error, 1);
    chk("t6_vld2", vld_out_2, 1);
    data_in = 8'h0C;
    pkt_valid = 1'b1;
    repeat (2) @(negedge clock);
    data_in = 8'hC1;
    @(negedge clock);
    chk("t6_mid_vld0", vld_out_0, 1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_flags", {vld_out_2, vld_out_1, vld_out_0, error, busy}, 5'b00000);
    chk("t6_rst_dout", {data_out_2, data_out_1, data_out_0}, 24'h000000);
    q0 = {};
    q1 = {};
    q2 = {};
    pkt_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("t6_post_rst", {vld_out_2, vld_out_1, vld_out_0, error, busy}, 5'b00000);
    chk("end_queues", q0.size() + q1.size() + q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
